// File: rtl/relu_stream_unit_if.sv
// Stream bundle for relu_stream_unit: the input beat channel with its
// per-beat controls, and the output beat channel.
//
// Handshake: a beat moves across a channel on a rising clock edge where valid
// and ready are both high. The producer holds valid and the payload
// steady until that edge. Ready may depend combinationally on the
// downstream ready.
interface relu_stream_unit_if #(
  parameter int LANES = 16,
  parameter int DW    = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*DW-1:0]   in_data;
  logic [1:0]            in_mode;
  logic                  in_last;
  logic [DW-1:0]         clamp_max;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*DW-1:0]   out_data;
  logic                  out_last;

  // Upstream/downstream environment view.
  modport master (
    output in_valid, in_data, in_mode, in_last, clamp_max, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // Activation stage view.
  modport slave (
    input  in_valid, in_data, in_mode, in_last, clamp_max, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/relu_stream_unit.sv
// relu_stream_unit: two-stage streaming activation (pass / ReLU / clamp /
// leaky ReLU) over LANES signed DW-bit lanes, with full back-pressure.
// S1 holds the raw beat and its controls; the activation is evaluated from S1
// and lands in S2, which drives the outputs directly.
// Optional macro RELU_STREAM_STATS_EN adds out_zero_cnt and out_sat, aligned
// with out_data.
module relu_stream_unit #(
  parameter int LANES      = 16,
  parameter int DW         = 8,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  relu_stream_unit_if.slave            bus,
`ifdef RELU_STREAM_STATS_EN
  output logic [$clog2(LANES+1)-1:0]   out_zero_cnt,
  output logic                         out_sat,
`endif
  output logic                         busy
);

  localparam int W = LANES * DW;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_RELU  = 2'b01,
    MODE_CLAMP = 2'b10,
    MODE_LEAKY = 2'b11
  } mode_e;

  // Stage 1: raw beat plus its per-beat controls.
  logic                 s1_v;
  logic [W-1:0]         s1_data;
  mode_e                s1_mode;
  logic signed [DW-1:0] s1_clamp;
  logic                 s1_last;

  // Stage 2: activated beat.
  logic                 s2_v;
  logic [W-1:0]         s2_data;
  logic                 s2_last;

  logic s1_take;
  logic s2_take;

  // Per-lane working values for the activation evaluated from S1.
  logic signed [DW-1:0] lane_x;
  logic signed [DW-1:0] lane_relu;
  logic signed [DW-1:0] lane_leaky;
  logic signed [DW-1:0] lane_y;
  logic                 lane_over;
  logic                 clamp_pos;
  logic [W-1:0]         act_data;

`ifdef RELU_STREAM_STATS_EN
  localparam int CW = $clog2(LANES+1);
  logic [CW-1:0] act_zero;
  logic          act_sat;
  logic [CW-1:0] s2_zero;
  logic          s2_sat;
`endif

  // A stage accepts when it is empty or its contents leave this cycle.
  assign s2_take      = !s2_v || bus.out_ready;
  assign s1_take      = !s1_v || s2_take;
  assign bus.in_ready = s1_take;

  assign bus.out_valid = s2_v;
  assign bus.out_data  = s2_data;
  assign bus.out_last  = s2_last;
  assign busy          = s1_v | s2_v;

`ifdef RELU_STREAM_STATS_EN
  assign out_zero_cnt = s2_zero;
  assign out_sat      = s2_sat;
`endif

  // Only a strictly positive clamp bound lets any value through.
  assign clamp_pos = !s1_clamp[DW-1] && (s1_clamp != {DW{1'b0}});

  // Lane-wise activation of the S1 beat, selected by that beat's own mode.
  always_comb begin
    act_data   = '0;
    lane_x     = '0;
    lane_relu  = '0;
    lane_leaky = '0;
    lane_y     = '0;
    lane_over  = 1'b0;
`ifdef RELU_STREAM_STATS_EN
    act_zero   = '0;
    act_sat    = 1'b0;
`endif
    for (int i = 0; i < LANES; i++) begin
      lane_x     = s1_data[(LANES-i)*DW-1 -: DW];
      lane_relu  = lane_x[DW-1] ? '0 : lane_x;
      lane_leaky = lane_x[DW-1] ? (lane_x >>> LEAK_SHIFT) : lane_x;
      lane_over  = lane_relu > s1_clamp;
      case (s1_mode)
        MODE_PASS:  lane_y = lane_x;
        MODE_RELU:  lane_y = lane_relu;
        MODE_CLAMP: lane_y = !clamp_pos ? '0 : (lane_over ? s1_clamp : lane_relu);
        default:    lane_y = lane_leaky;
      endcase
      act_data[(LANES-i)*DW-1 -: DW] = lane_y;
`ifdef RELU_STREAM_STATS_EN
      if (lane_y == '0) act_zero = act_zero + CW'(1);
      if ((s1_mode == MODE_CLAMP) && (lane_y != lane_relu)) act_sat = 1'b1;
`endif
    end
  end

  // S1 register: capture the accepted beat; hold when blocked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v     <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= MODE_PASS;
      s1_clamp <= '0;
      s1_last  <= 1'b0;
    end else if (s1_take) begin
      s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        s1_data  <= bus.in_data;
        s1_mode  <= mode_e'(bus.in_mode);
        s1_clamp <= bus.clamp_max;
        s1_last  <= bus.in_last;
      end
    end
  end

  // S2 register: capture the activated beat; hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v    <= 1'b0;
      s2_data <= '0;
      s2_last <= 1'b0;
`ifdef RELU_STREAM_STATS_EN
      s2_zero <= '0;
      s2_sat  <= 1'b0;
`endif
    end else if (s2_take) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_data <= act_data;
        s2_last <= s1_last;
`ifdef RELU_STREAM_STATS_EN
        s2_zero <= act_zero;
        s2_sat  <= act_sat;
`endif
      end
    end
  end

endmodule

// File: tb/tb_relu_stream_unit.sv
// Directed self-checking bench for relu_stream_unit (LANES=4, DW=8,
// LEAK_SHIFT=3). Stats checks are compiled in with RELU_STREAM_STATS_EN.
module tb_relu_stream_unit;
  localparam int LANES      = 4;
  localparam int DW         = 8;
  localparam int LEAK_SHIFT = 3;
  localparam int W          = LANES * DW;
  localparam int CW         = $clog2(LANES+1);

  logic clk = 1'b0;
  logic rst;
  logic busy;
`ifdef RELU_STREAM_STATS_EN
  logic [CW-1:0] out_zero_cnt;
  logic          out_sat;
`endif

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  relu_stream_unit_if #(.LANES(LANES), .DW(DW)) bus ();

  // Clock and reset block.
  always #5 clk = ~clk;

  relu_stream_unit #(.LANES(LANES), .DW(DW), .LEAK_SHIFT(LEAK_SHIFT)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
`ifdef RELU_STREAM_STATS_EN
    .out_zero_cnt (out_zero_cnt),
    .out_sat      (out_sat),
`endif
    .busy         (busy)
  );

  // Driver: quiet input channel.
  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = 2'b00;
    bus.in_last   = 1'b0;
    bus.clamp_max = '0;
  endtask

  // Driver: one beat with out_ready=1; returns at the cycle its output is due.
  task automatic drive_single(input logic [W-1:0] d, input logic [1:0] m,
                              input logic [DW-1:0] cm);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_mode   = m;
    bus.clamp_max = cm;
    bus.in_last   = 1'b0;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (bus.out_data !== '0) begin failures++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    checks++; if (bus.out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
`ifdef RELU_STREAM_STATS_EN
    checks++; if (out_zero_cnt !== '0 || out_sat !== 1'b0) begin failures++; $display("FAIL reset_stats: got %0d/%b want 0/0", out_zero_cnt, out_sat); end
`endif
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_relu();
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h807F_FF05;
    bus.in_mode   = 2'b01;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL relu_accept: got %b want 1", bus.in_ready); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL relu_early: got %b want 0", bus.out_valid); end
    @(negedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL relu_latency: got %b want 1", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h007F_0005) begin failures++; $display("FAIL relu_data: got %h want 007f0005", bus.out_data); end
`ifdef RELU_STREAM_STATS_EN
    checks++; if (out_zero_cnt !== 3'd2) begin failures++; $display("FAIL relu_zero_cnt: got %0d want 2", out_zero_cnt); end
`endif
    @(negedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL relu_dup: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_clamp();
    drive_single(32'h0506_07F0, 2'b10, 8'h06);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0506_0600) begin failures++; $display("FAIL clamp_data: got %b/%h want 1/05060600", bus.out_valid, bus.out_data); end
`ifdef RELU_STREAM_STATS_EN
    checks++; if (out_sat !== 1'b1 || out_zero_cnt !== 3'd1) begin failures++; $display("FAIL clamp_stats: got %b/%0d want 1/1", out_sat, out_zero_cnt); end
`endif
    // Non-positive bound: every lane collapses to zero.
    drive_single(32'h0500_807F, 2'b10, 8'hF0);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000_0000) begin failures++; $display("FAIL clamp_neg_bound: got %b/%h want 1/00000000", bus.out_valid, bus.out_data); end
    drive_single(32'h0500_807F, 2'b10, 8'h00);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000_0000) begin failures++; $display("FAIL clamp_zero_bound: got %b/%h want 1/00000000", bus.out_valid, bus.out_data); end
  endtask

  task automatic test_leaky();
    drive_single(32'hF0FF_8010, 2'b11, 8'h00);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hFEFF_F010) begin failures++; $display("FAIL leaky_data: got %b/%h want 1/feff f010", bus.out_valid, bus.out_data); end
`ifdef RELU_STREAM_STATS_EN
    checks++; if (out_sat !== 1'b0 || out_zero_cnt !== 3'd0) begin failures++; $display("FAIL leaky_stats: got %b/%0d want 0/0", out_sat, out_zero_cnt); end
`endif
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int rcvd = 0;
    int occ  = 0;
    int cyc  = 0;
    int stall_cycles = 0;
    logic [3:0] pat = 4'b1001;
    logic prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic [W-1:0] exp_v;
    logic acc, emit;
    exp_q.delete();
    while (rcvd < 8 && cyc < 200) begin
      @(negedge clk);
      bus.out_ready = pat[cyc % 4];
      bus.in_valid  = (sent < 8);
      bus.in_data   = {8'h10 + 8'(sent), 8'h80, 8'h7F, 8'(sent)};
      bus.in_mode   = 2'b01;
      bus.clamp_max = 8'h00;
      #1;
      if (prev_stall) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin failures++; $display("FAIL stall_hold: got %b/%h want 1/%h", bus.out_valid, bus.out_data, prev_data); end
      end
      checks++; if (bus.in_ready !== !(occ == 2 && !bus.out_ready)) begin failures++; $display("FAIL b2b_in_ready: got %b want %b (occ=%0d)", bus.in_ready, !(occ == 2 && !bus.out_ready), occ); end
      if (!bus.in_ready) stall_cycles++;
      acc  = bus.in_valid && bus.in_ready;
      emit = bus.out_valid && bus.out_ready;
      if (emit) begin
        if (exp_q.size() == 0) begin
          checks++; failures++; $display("FAIL b2b_extra: got %h want none", bus.out_data);
        end else begin
          exp_v = exp_q.pop_front();
          checks++; if (bus.out_data !== exp_v) begin failures++; $display("FAIL b2b_data: got %h want %h", bus.out_data, exp_v); end
        end
        rcvd++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (acc) begin
        exp_q.push_back({8'h10 + 8'(sent), 8'h00, 8'h7F, 8'(sent)});
        sent++;
      end
      occ = occ + int'(acc) - int'(emit);
      cyc++;
    end
    idle_inputs();
    bus.out_ready = 1'b1;
    checks++; if (rcvd != 8 || exp_q.size() != 0) begin failures++; $display("FAIL b2b_count: got %0d left %0d want 8 left 0", rcvd, exp_q.size()); end
    checks++; if (stall_cycles == 0) begin failures++; $display("FAIL b2b_backpressure: got 0 stall cycles want >0"); end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_drain_busy: got %b want 0", busy); end
  endtask

  task automatic test_modes();
    logic [W-1:0] md_exp [4];
    logic [CW-1:0] md_zero [4];
    logic md_sat [4];
    int n = 0;
    md_exp[0] = 32'h8001_7FFE; md_zero[0] = 3'd0; md_sat[0] = 1'b0;
    md_exp[1] = 32'h0001_7F00; md_zero[1] = 3'd2; md_sat[1] = 1'b0;
    md_exp[2] = 32'h0001_1000; md_zero[2] = 3'd2; md_sat[2] = 1'b1;
    md_exp[3] = 32'hF001_7FFF; md_zero[3] = 3'd0; md_sat[3] = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = (cyc < 4);
      bus.in_data   = 32'h8001_7FFE;
      bus.in_mode   = 2'(cyc);
      bus.clamp_max = 8'h10;
      bus.in_last   = (cyc == 3);
      #1;
      if (bus.out_valid === 1'b1 && n < 4) begin
        if (n == 0) begin
          checks++; if (cyc != 2) begin failures++; $display("FAIL modes_latency: got cycle %0d want 2", cyc); end
        end
        checks++; if (bus.out_data !== md_exp[n]) begin failures++; $display("FAIL modes_data%0d: got %h want %h", n, bus.out_data, md_exp[n]); end
        checks++; if (bus.out_last !== (n == 3)) begin failures++; $display("FAIL modes_last%0d: got %b want %b", n, bus.out_last, (n == 3)); end
`ifdef RELU_STREAM_STATS_EN
        checks++; if (out_zero_cnt !== md_zero[n] || out_sat !== md_sat[n]) begin failures++; $display("FAIL modes_stats%0d: got %0d/%b want %0d/%b", n, out_zero_cnt, out_sat, md_zero[n], md_sat[n]); end
`endif
        n++;
      end else if (bus.out_valid === 1'b1) begin
        checks++; failures++; $display("FAIL modes_extra: got %h want none", bus.out_data);
      end
    end
    idle_inputs();
    checks++; if (n != 4) begin failures++; $display("FAIL modes_count: got %0d want 4", n); end
  endtask

  task automatic test_reset_midstream();
    int stale = 0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h1111_1111;
    bus.in_mode   = 2'b00;
    @(negedge clk);
    bus.in_data   = 32'h2222_2222;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (busy !== 1'b1 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL mid_full: got busy=%b valid=%b want 1/1", busy, bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL mid_in_ready_full: got %b want 0", bus.in_ready); end
    rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_reset_async: got valid=%b busy=%b want 0/0", bus.out_valid, busy); end
    checks++; if (bus.out_data !== '0) begin failures++; $display("FAIL mid_reset_data: got %h want 0", bus.out_data); end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready_after: got %b want 1", bus.in_ready); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin failures++; $display("FAIL mid_stale: got %0d stale cycles want 0", stale); end
  endtask

  // Sequence and final report.
  initial begin
    bus.out_ready = 1'b1;
    idle_inputs();
    test_reset();
    test_relu();
    test_clamp();
    test_leaky();
    test_back_to_back();
    test_modes();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/relu_stream_unit.md
Name: relu_stream_unit

Overview:
- Streaming, parametrised activation stage for the CNN accelerator datapath. Sits between the MAC/accumulator array and the output buffer.
- Accepts one packed vector of LANES signed values per beat over a valid/ready handshake. Applies a per-beat selectable activation (pass, ReLU, clamped ReLU, leaky ReLU) in a 2-stage pipeline.
- Generalises the fixed 16x8-bit combinational ReLU: width, lane count, modes and back-pressure.

Parameters:
- LANES, 16, number of parallel lanes per beat.
- DW, 8, lane width in bits, signed two's complement.
- LEAK_SHIFT, 3, arithmetic right-shift applied to negative lanes in leaky mode (slope 2^-LEAK_SHIFT).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  LANES*DW  packed lanes; lane 0 in MSBs, lane i at bits [(LANES-i)*DW-1 -: DW].
- in_mode  input  2  activation for this beat: 00 pass, 01 ReLU, 10 clamp, 11 leaky.
- in_last  input  1  marks last beat of a feature-map row; carried through.
- clamp_max  input  DW  signed upper bound for clamp mode; sampled with the beat.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accept.
- out_data  output  LANES*DW  activated lanes, same packing as in_data.
- out_last  output  1  in_last of the same beat.
- busy  output  1  high while either pipeline stage holds a beat.

Behaviour:
- Reset: while rst is high, all valids clear immediately (asynchronous). out_valid=0, out_data=0, out_last=0, busy=0. in_ready=1 from the first cycle after rst deasserts.
- Pipeline: S1 and S2 registers, each with its own valid bit. out_* are driven directly from S2. Latency is 2 cycles from acceptance to out_valid with no stall. Throughput is 1 beat/cycle.
- Advance rules:
  - s2_take = !s2_v || out_ready.
  - s1_take = !s1_v || s2_take.
  - in_ready = s1_take, a combinational path through out_ready.
  - A stage not taking new data holds its contents unchanged.
- Handshake:
  - out_data and out_last are stable while out_valid && !out_ready.
  - No beat is dropped or duplicated.
  - in_data is ignored unless in_valid && in_ready.
- S1 stage: register the beat plus in_mode and clamp_max. Compute per lane:
  - neg = x[DW-1].
  - relu = neg ? 0 : x.
  - leaky = neg ? (x >>> LEAK_SHIFT) : x, with sign extension. A lane equal to -1 stays -1.
- S2 stage:
  - Pass: x unchanged.
  - ReLU: relu.
  - Leaky: leaky.
  - Clamp: relu if relu <= clamp_max (signed compare), else clamp_max. If clamp_max <= 0, every lane outputs 0.
- Mode and clamp_max are per beat: changing them between consecutive beats affects only later beats.
- Simultaneous accept and emit in the same cycle is legal and sustains full rate.
- busy = s1_v | s2_v.
- Reset mid-stream discards in-flight beats. No partial output is produced.

Optional Feature:
- Macro: RELU_STREAM_STATS_EN.
- Defined: adds outputs out_zero_cnt (width $clog2(LANES+1)) and out_sat (1).
  - Both are aligned with out_data and held under stall.
  - out_zero_cnt = number of lanes of the output beat equal to 0.
  - out_sat = 1 if any lane was limited to clamp_max in clamp mode.
  - Both are computed in S1/S2 with no added latency; reset value 0.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- LANES=4, DW=8, mode=01, in_data=0x80_7F_FF_05, out_ready=1 -> out_data=0x00_7F_00_05 exactly 2 cycles after accept; zero_cnt=2 if STATS.
- mode=10, clamp_max=0x06, in_data=0x05_06_07_F0 -> out_data=0x05_06_06_00; out_sat=1.
- mode=11, LEAK_SHIFT=3, in_data=0xF0_FF_80_10 -> out_data=0xFE_FF_F0_10.
- Stream 8 beats with in_valid=1 while out_ready toggles 1,0,0,1: all 8 appear in order, no loss. out_data is stable during stalls. in_ready falls to 0 only when both stages are full and out_ready=0.
- Alternate mode per beat (00,01,10,11) with the same data 0x80_01_7F_FE, clamp_max=0x10 -> each output matches its own beat's mode. in_last on beat 4 appears as out_last on output 4 only.
- Assert rst with 2 beats in flight -> out_valid=0 and busy=0 immediately. After release, in_ready=1 and no stale beat is emitted.
